// File: rtl/channel_err_inj_pkg.sv
// channel_err_inj_pkg: shared types and constants for the channel error injector.
package channel_err_inj_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_BURST = 2'b01,
        MODE_RAND  = 2'b10,
        MODE_BOTH  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/channel_err_inj_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, shifts left with feedback into bit 0 when enabled.
module lfsr16
    import channel_err_inj_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= seed;
        else if (en)
            state <= {state[14:0], ^(state & LFSR_TAPS)};
    end

endmodule

// File: rtl/channel_err_inj.sv
// channel_err_inj: corrupts encoder symbols with periodic bursts and/or LFSR-driven random flips
// inside a post-reset window, with 1-cycle latency and saturating statistics counters.
module channel_err_inj
    import channel_err_inj_pkg::*;
#(
    parameter int          N         = 5,
    parameter int          BURST_LEN = 4,
    parameter int          WINDOW    = 256,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [1:0]       sym_i,
    input  logic [1:0]       mode_i,
    input  logic [1:0]       mask_i,
    input  logic [3:0]       rate_i,
    output logic             valid_o,
    output logic [1:0]       sym_o,
    output logic             err_o,
    output logic [CNT_W-1:0] word_ct_o,
    output logic [CNT_W-1:0] inj_ct_o,
    output logic [CNT_W-1:0] bit_ct_o
);

    localparam int RW = N + 1;
    localparam logic [N-1:0] START = N'(2**N - BURST_LEN);

    state_t        state, state_n;
    logic [RW-1:0] rem, rem_n;
    logic [15:0]   lfsr;
    mode_t         mode;
    logic          burst_en, rand_en, in_win, last, start, burst_hit, rand_hit;
    logic [1:0]    rand_mask, mask, pc;
    logic          unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (valid_i),
        .seed  (SEED),
        .state (lfsr)
    );

    assign unused = ^lfsr[11:2];

    always_comb begin
        mode      = mode_t'(mode_i);
        burst_en  = mode inside {MODE_BURST, MODE_BOTH};
        rand_en   = mode inside {MODE_RAND, MODE_BOTH};
        in_win    = int'({16'b0, word_ct_o}) < WINDOW;
        last      = int'({16'b0, word_ct_o}) == WINDOW - 1;
        start     = state == IDLE && burst_en && in_win && word_ct_o[N-1:0] == START;
        burst_hit = burst_en && (start || state == BURST);
        rand_hit  = rand_en && in_win && lfsr[15:12] < rate_i;
        rand_mask = lfsr[1:0] != 2'b00 ? lfsr[1:0] : 2'b01;
        mask      = (burst_hit ? mask_i : 2'b00) | (rand_hit ? rand_mask : 2'b00);
        pc        = {1'b0, mask[1]} + {1'b0, mask[0]};
    end

    // Window end wins over burst bookkeeping; the last symbol was already masked above
    always_comb begin
        state_n = state;
        rem_n   = rem;
        if (valid_i) begin
            if (last)
                state_n = DONE;
            else if (start) begin
                state_n = BURST_LEN == 1 ? IDLE : BURST;
                rem_n   = RW'(BURST_LEN - 1);
            end else if (state == BURST) begin
                state_n = (!burst_en || rem == RW'(1)) ? IDLE : BURST;
                rem_n   = rem - RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o   <= 1'b0;
            sym_o     <= 2'b00;
            err_o     <= 1'b0;
            word_ct_o <= '0;
            inj_ct_o  <= '0;
            bit_ct_o  <= '0;
        end else begin
            valid_o <= valid_i;
            err_o   <= valid_i && mask != 2'b00;
            if (valid_i) begin
                sym_o     <= sym_i ^ mask;
                word_ct_o <= sat_add(word_ct_o, 2'd1);
                inj_ct_o  <= sat_add(inj_ct_o, {1'b0, mask != 2'b00});
                bit_ct_o  <= sat_add(bit_ct_o, pc);
            end
        end
    end

endmodule

// File: tb/tb_channel_err_inj.sv
// tb_channel_err_inj: directed self-checking bench for channel_err_inj with default parameters.
module tb_channel_err_inj;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [1:0]  sym_i = 2'b00, mode_i = 2'b00, mask_i = 2'b00;
    logic [3:0]  rate_i = 4'd0;
    logic        valid_o, err_o;
    logic [1:0]  sym_o;
    logic [15:0] word_ct_o, inj_ct_o, bit_ct_o;

    int checks = 0;
    int errors = 0;

    channel_err_inj dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .sym_i     (sym_i),
        .mode_i    (mode_i),
        .mask_i    (mask_i),
        .rate_i    (rate_i),
        .valid_o   (valid_o),
        .sym_o     (sym_o),
        .err_o     (err_o),
        .word_ct_o (word_ct_o),
        .inj_ct_o  (inj_ct_o),
        .bit_ct_o  (bit_ct_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic exp_err, input logic [1:0] exp_sym);
        valid_i = v;
        sym_i   = s;
        @(posedge clk);
        #1;
        check("valid_o", 32'(valid_o), 32'(v));
        check("err_o", 32'(err_o), 32'(exp_err));
        check("sym_o", 32'(sym_o), 32'(exp_sym));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(valid_o), 0);
        check({tag, "_sym"}, 32'(sym_o), 0);
        check({tag, "_err"}, 32'(err_o), 0);
        check({tag, "_word"}, 32'(word_ct_o), 0);
        check({tag, "_inj"}, 32'(inj_ct_o), 0);
        check({tag, "_bit"}, 32'(bit_ct_o), 0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");
    endtask

    function automatic logic burst_k(input int k);
        return k < 256 && (k % 32) >= 28;
    endfunction

    initial begin
        logic        e;
        logic [1:0]  s, mk, last_sym;
        logic [15:0] m;
        int          exp_inj, exp_bit;

        // Periodic bursts, mask 10 on symbol 11
        do_reset();
        mode_i = 2'b01; mask_i = 2'b10;
        for (int k = 0; k < 300; k++) begin
            e = burst_k(k);
            step(1'b1, 2'b11, e, e ? 2'b01 : 2'b11);
        end
        check("burst_word", 32'(word_ct_o), 300);
        check("burst_inj", 32'(inj_ct_o), 32);
        check("burst_bit", 32'(bit_ct_o), 32);

        // Pass-through mode
        do_reset();
        mode_i = 2'b00;
        for (int k = 0; k < 300; k++) begin
            s = 2'(k);
            step(1'b1, s, 1'b0, s);
        end
        check("off_word", 32'(word_ct_o), 300);
        check("off_inj", 32'(inj_ct_o), 0);

        // Random mode with rate 0 never injects
        do_reset();
        mode_i = 2'b10; rate_i = 4'd0;
        for (int k = 0; k < 300; k++)
            step(1'b1, 2'b10, 1'b0, 2'b10);
        check("rate0_inj", 32'(inj_ct_o), 0);

        // Random mode, rate 15, against a reference LFSR
        do_reset();
        rate_i = 4'd15; mask_i = 2'b11;
        m = 16'hACE1; exp_inj = 0; exp_bit = 0;
        for (int k = 0; k < 300; k++) begin
            e  = k < 256 && m[15:12] < 4'd15;
            mk = e ? (m[1:0] != 2'b00 ? m[1:0] : 2'b01) : 2'b00;
            if (e) begin
                exp_inj++;
                exp_bit += int'(mk[0]) + int'(mk[1]);
            end
            step(1'b1, 2'b00, e, mk);
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end
        check("rand_inj", 32'(inj_ct_o), 32'(exp_inj));
        check("rand_bit", 32'(bit_ct_o), 32'(exp_bit));

        // Bursts with valid toggling, mask 11
        do_reset();
        mode_i = 2'b01; mask_i = 2'b11; rate_i = 4'd0;
        last_sym = 2'b00;
        for (int c = 0; c < 256; c++) begin
            if (c % 2 == 0) begin
                e = burst_k(c / 2);
                last_sym = e ? 2'b00 : 2'b11;
                step(1'b1, 2'b11, e, last_sym);
            end else
                step(1'b0, 2'b11, 1'b0, last_sym);
        end
        check("toggle_word", 32'(word_ct_o), 128);
        check("toggle_inj", 32'(inj_ct_o), 16);
        check("toggle_bit", 32'(bit_ct_o), 32);

        // Asynchronous reset in the middle of a burst
        do_reset();
        mode_i = 2'b01; mask_i = 2'b01;
        for (int k = 0; k < 30; k++) begin
            e = burst_k(k);
            step(1'b1, 2'b11, e, e ? 2'b10 : 2'b11);
        end
        #2 rst = 1'b1;
        #1 check_zero("async");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            e = burst_k(k);
            step(1'b1, 2'b11, e, e ? 2'b10 : 2'b11);
        end
        check("restart_inj", 32'(inj_ct_o), 4);

        // Burst aborted by clearing mode_i[0], then re-enabled
        do_reset();
        mask_i = 2'b10;
        for (int k = 0; k < 64; k++) begin
            mode_i = (k >= 29 && k <= 31) ? 2'b00 : 2'b01;
            e = burst_k(k) && !(k >= 29 && k <= 31);
            step(1'b1, 2'b11, e, e ? 2'b01 : 2'b11);
        end
        check("abort_inj", 32'(inj_ct_o), 5);
        check("abort_bit", 32'(bit_ct_o), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_err_inj.md
CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

Interface
REQ-001 Parameters: N (default 5), 2**N = burst period in symbols.
REQ-002 Parameter BURST_LEN (default 4), consecutive corrupted symbols per burst; legal range 1..2**N.
REQ-003 Parameter WINDOW (default 256), number of symbols after reset during which injection is allowed.
REQ-004 Parameter SEED (default 16'hACE1), LFSR reset value; nonzero.
REQ-005 Ports: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 valid_i  in  1  symbol strobe from the convolutional encoder.
REQ-008 sym_i  in  2  encoder output symbol.
REQ-009 mode_i  in  2  injection mode: 00 off, 01 periodic burst, 10 random, 11 burst OR random.
REQ-010 mask_i  in  2  bits flipped during a burst symbol.
REQ-011 rate_i  in  4  random threshold; 0 disables random injection.
REQ-012 valid_o  out  1  symbol strobe to the Viterbi decoder.
REQ-013 sym_o  out  2  possibly corrupted symbol.
REQ-014 err_o  out  1  sym_o differs from its source symbol.
REQ-015 word_ct_o  out  16  symbols accepted since reset.
REQ-016 inj_ct_o  out  16  corrupted symbols.
REQ-017 bit_ct_o  out  16  flipped bits.

Function
REQ-018 Latency: exactly 1 cycle; valid_o is valid_i delayed by one cycle, and sym_o = sym_i XOR applied mask from that same cycle.
REQ-019 When valid_i=0: valid_o=0, err_o=0, sym_o holds, and the LFSR, FSM and all counters hold.
REQ-020 word_ct increments per accepted symbol and saturates at 16'hFFFF.
REQ-021 Symbol index k = word_ct value before increment; injection only while k < WINDOW.
REQ-022 FSM states: IDLE, BURST, DONE.
REQ-023 IDLE->BURST on an accepted symbol with mode_i[0]=1, k<WINDOW, and k[N-1:0] == 2**N-BURST_LEN; that symbol is the first burst symbol.
REQ-024 BURST: each accepted symbol uses mask_i and decrements the remaining count; after the BURST_LEN-th symbol go to IDLE.
REQ-025 Any state -> DONE on the accepted symbol with k = WINDOW-1; that symbol is still corruptible; DONE is a pure pass-through, exited only by reset.
REQ-026 mode_i[0] deasserted while in BURST: burst aborts to IDLE, and the current symbol is not burst-corrupted.
REQ-027 Burst mask is zero whenever mode_i[0]=0.
REQ-028 LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift-left with feedback into bit 0; advances once per accepted symbol regardless of mode.
REQ-029 Random hit when mode_i[1]=1, k<WINDOW, and lfsr[15:12] < rate_i (pre-advance value).
REQ-030 Random mask = lfsr[1:0] if nonzero, else 2'b01.
REQ-031 Applied mask = burst mask OR random mask.
REQ-032 err_o = 1 iff the applied mask is nonzero.
REQ-033 inj_ct increments by 1 per nonzero mask; bit_ct increments by popcount of the mask (0..2); both saturate at 16'hFFFF.

Reset
REQ-034 On rst: valid_o=0, sym_o=2'b00, err_o=0, all counters 0, FSM=IDLE, LFSR=SEED.
REQ-035 Reset mid-burst discards the burst; the first post-reset symbol has k=0.
REQ-036 Deassertion is synchronized externally; no symbol is accepted in the cycle rst is high.

Structure
REQ-037 Shared package holds the mode encoding enum, the FSM state enum, the LFSR tap constant and the counter width (16).
REQ-038 One sub-module, lfsr16 (enable, seed, state out); everything else stays in channel_err_inj.

Verification
REQ-039 Defaults, mode 01, mask 10, valid_i every cycle, sym_i=11 -> corrupted symbols k=28..31, 60..63, ..., 252..255 read sym_o=01; inj_ct=32, bit_ct=32; 0 errors after k=255.
REQ-040 mode 00, 300 symbols -> sym_o equals sym_i delayed 1 cycle; inj_ct=0; word_ct=300.
REQ-041 mode 10, rate 0 -> no injection; rate 15 -> inj_ct equals the count of symbols with lfsr[15:12]<15 per reference LFSR model.
REQ-042 valid_i toggling 1/0 -> word_ct=128 after 256 cycles; bursts on identical k values as REQ-039.
REQ-043 rst asserted at k=29 during a burst -> outputs zero immediately; restart yields first burst at k=28.
REQ-044 mode_i[0] cleared at k=29 -> k=29..31 clean; next burst at k=60 when re-enabled.
